// File: rtl/icache_responder_pkg.sv
// Shared definitions for the instruction cache responder.
// Provides the CPU-side bus types (CacheAddrBus, CacheDataBus, CacheByteBus),
// the ZeroWord constant and the controller state encoding.
package icache_responder_pkg;

  localparam int unsigned ADDR_W = 25;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned BYTE_W = DATA_W / 8;

  typedef logic [ADDR_W-1:0] CacheAddrBus;
  typedef logic [DATA_W-1:0] CacheDataBus;
  typedef logic [BYTE_W-1:0] CacheByteBus;

  localparam CacheDataBus ZeroWord = '0;

  typedef enum logic [1:0] {
    RUN         = 2'd0,
    REFILL_REQ  = 2'd1,
    REFILL_DATA = 2'd2,
    RESP        = 2'd3
  } state_t;

endpackage

// File: rtl/icache_responder_sram.sv
// icache_sram: simple dual-port RAM, one write port and one synchronous read
// port. Read data updates only on a cycle where re is high and holds otherwise.
// Ports: clk, we/waddr/wdata (write), re/raddr/rdata (registered read).
module icache_sram #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned ADDR_BITS = 8
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [ADDR_BITS-1:0] waddr,
  input  logic [WIDTH-1:0]     wdata,
  input  logic                 re,
  input  logic [ADDR_BITS-1:0] raddr,
  output logic [WIDTH-1:0]     rdata
);

  logic [WIDTH-1:0] mem [2**ADDR_BITS];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/icache_responder.sv
// icache_responder: read-only direct-mapped instruction cache.
// CPU slave side (s_*): one word read per cycle, 1-cycle hit latency, stalls
// with s_waitrequest on a miss. Memory master side (m_*): fixed-length burst
// refill of one line. flush invalidates every line.
// Optional macro ICACHE_STATS_EN adds stat_hits / stat_misses counters.
module icache_responder
  import icache_responder_pkg::*;
#(
  parameter int unsigned INDEX_BITS      = 6,
  parameter int unsigned LINE_WORDS_LOG2 = 2
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  CacheAddrBus                s_addr,
  input  CacheByteBus                s_byte_en,
  input  CacheDataBus                s_writedata,
  input  logic                       s_read,
  input  logic                       s_write,
  output CacheDataBus                s_readdata,
  output logic                       s_readdata_valid,
  output logic                       s_waitrequest,
  input  logic                       flush,
  output CacheAddrBus                m_addr,
  output logic                       m_read,
  output logic [LINE_WORDS_LOG2:0]   m_burstcount,
  input  CacheDataBus                m_readdata,
  input  logic                       m_readdata_valid,
  input  logic                       m_waitrequest
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0]                stat_hits,
  output logic [31:0]                stat_misses
`endif
);

  localparam int unsigned LWL        = LINE_WORDS_LOG2;
  localparam int unsigned LINE_WORDS = 1 << LWL;
  localparam int unsigned TAG_BITS   = ADDR_W - INDEX_BITS - LWL;
  localparam int unsigned LINES      = 1 << INDEX_BITS;

  state_t                  state;
  CacheAddrBus             lk_addr;
  logic                    lk_valid;
  logic [LINES-1:0]        valid_q;
  logic [LWL-1:0]          beat;
  CacheDataBus             resp_word;
  logic                    refill_flushed;

  logic [LWL-1:0]          lk_off;
  logic [INDEX_BITS-1:0]   lk_idx;
  logic [TAG_BITS-1:0]     lk_tag;
  logic [INDEX_BITS-1:0]   s_idx;
  logic [LWL-1:0]          s_off;
  logic [TAG_BITS-1:0]     tag_rdata;
  CacheDataBus             data_rdata;
  logic                    hit;
  logic                    miss;
  logic                    accept;
  logic                    data_we;
  logic                    tag_we;
  logic                    unused_ok;

  assign lk_off = lk_addr[LWL-1:0];
  assign lk_idx = lk_addr[LWL +: INDEX_BITS];
  assign lk_tag = lk_addr[ADDR_W-1 -: TAG_BITS];
  assign s_off  = s_addr[LWL-1:0];
  assign s_idx  = s_addr[LWL +: INDEX_BITS];

  // Writes are accepted and dropped; byte enables and write data never matter.
  assign unused_ok = ^{s_byte_en, s_writedata, s_write};

  assign m_burstcount = (LWL+1)'(LINE_WORDS);

  // Compare stage: uses RAM outputs from the accept edge and the live valid
  // flops, so a flush on the accept edge turns this lookup into a miss.
  assign hit  = (state == RUN) && lk_valid && valid_q[lk_idx] && (tag_rdata == lk_tag);
  assign miss = (state == RUN) && lk_valid && !hit;

  assign s_waitrequest = (state == REFILL_REQ) || (state == REFILL_DATA) || miss;
  assign accept        = s_read && !s_waitrequest;

  assign data_we = (state == REFILL_DATA) && m_readdata_valid;
  assign tag_we  = data_we && (&beat);

  always_comb begin
    s_readdata_valid = 1'b0;
    s_readdata       = ZeroWord;
    if (hit) begin
      s_readdata_valid = 1'b1;
      s_readdata       = data_rdata;
    end else if (state == RESP) begin
      s_readdata_valid = 1'b1;
      s_readdata       = resp_word;
    end
  end

  icache_sram #(.WIDTH(DATA_W), .ADDR_BITS(INDEX_BITS + LWL)) u_data (
    .clk   (clk),
    .we    (data_we),
    .waddr ({lk_idx, beat}),
    .wdata (m_readdata),
    .re    (accept),
    .raddr ({s_idx, s_off}),
    .rdata (data_rdata)
  );

  icache_sram #(.WIDTH(TAG_BITS), .ADDR_BITS(INDEX_BITS)) u_tag (
    .clk   (clk),
    .we    (tag_we),
    .waddr (lk_idx),
    .wdata (lk_tag),
    .re    (accept),
    .raddr (s_idx),
    .rdata (tag_rdata)
  );

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state          <= RUN;
      lk_valid       <= 1'b0;
      lk_addr        <= '0;
      valid_q        <= '0;
      beat           <= '0;
      resp_word      <= ZeroWord;
      refill_flushed <= 1'b0;
      m_read         <= 1'b0;
      m_addr         <= '0;
    end else begin
      // lk_addr is held through the refill because nothing is accepted then.
      lk_valid <= accept;
      if (accept) lk_addr <= s_addr;

      case (state)
        RUN: begin
          if (miss) begin
            state          <= REFILL_REQ;
            m_read         <= 1'b1;
            m_addr         <= {lk_tag, lk_idx, {LWL{1'b0}}};
            refill_flushed <= flush;
          end
        end
        REFILL_REQ: begin
          if (flush) refill_flushed <= 1'b1;
          if (!m_waitrequest) begin
            m_read <= 1'b0;
            state  <= REFILL_DATA;
          end
        end
        REFILL_DATA: begin
          if (flush) refill_flushed <= 1'b1;
          if (m_readdata_valid) begin
            beat <= beat + 1'b1;
            if (beat == lk_off) resp_word <= m_readdata;
            if (&beat) begin
              state <= RESP;
              if (!refill_flushed) valid_q[lk_idx] <= 1'b1;
            end
          end
        end
        RESP: state <= RUN;
        default: state <= RUN;
      endcase

      // Placed last so a flush on the final-beat edge also wins over the install.
      if (flush) valid_q <= '0;
    end
  end

`ifdef ICACHE_STATS_EN
  always_ff @(posedge clk) begin
    if (!rstn) begin
      stat_hits   <= '0;
      stat_misses <= '0;
    end else begin
      if (hit)  stat_hits   <= stat_hits + 32'd1;
      if (miss) stat_misses <= stat_misses + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_icache_responder.sv
module tb_icache_responder;

  logic        clk;
  logic        rstn;
  logic [24:0] s_addr;
  logic [3:0]  s_byte_en;
  logic [31:0] s_writedata;
  logic        s_read;
  logic        s_write;
  logic [31:0] s_readdata;
  logic        s_readdata_valid;
  logic        s_waitrequest;
  logic        flush;
  logic [24:0] m_addr;
  logic        m_read;
  logic [2:0]  m_burstcount;
  logic [31:0] m_readdata;
  logic        m_readdata_valid;
  logic        m_waitrequest;
`ifdef ICACHE_STATS_EN
  logic [31:0] stat_hits;
  logic [31:0] stat_misses;
`endif

  icache_responder #(.INDEX_BITS(6), .LINE_WORDS_LOG2(2)) dut (
    .clk              (clk),
    .rstn             (rstn),
    .s_addr           (s_addr),
    .s_byte_en        (s_byte_en),
    .s_writedata      (s_writedata),
    .s_read           (s_read),
    .s_write          (s_write),
    .s_readdata       (s_readdata),
    .s_readdata_valid (s_readdata_valid),
    .s_waitrequest    (s_waitrequest),
    .flush            (flush),
    .m_addr           (m_addr),
    .m_read           (m_read),
    .m_burstcount     (m_burstcount),
    .m_readdata       (m_readdata),
    .m_readdata_valid (m_readdata_valid),
    .m_waitrequest    (m_waitrequest)
`ifdef ICACHE_STATS_EN
    ,
    .stat_hits        (stat_hits),
    .stat_misses      (stat_misses)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int exp_hits = 0;
  int exp_misses = 0;

  // Reference model: which line each index holds, and read-only backing memory.
  bit          mv [64];
  logic [16:0] mt [64];

  function automatic logic [31:0] mem_word(input logic [24:0] a);
    if (a >= 25'h10 && a <= 25'h13) return 32'hA0 + 32'(a - 25'h10);
    return (32'(a) * 32'h9E3779B1) ^ 32'h5A5A1234;
  endfunction

  task automatic clear_model();
    for (int i = 0; i < 64; i++) mv[i] = 1'b0;
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic checkw(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Called #1 after a rising edge with the cache idle; returns likewise.
  // fmode: 0 none, 1 flush on the accept edge, 2 flush mid-burst,
  //        3 flush during the compare cycle (used on hits).
  task automatic do_read(input logic [24:0] addr, input int unsigned fmode,
                         input int unsigned wcycles);
    logic [24:0] base;
    logic [16:0] tg;
    logic [1:0]  off;
    int          idx;
    bit          exp_hit;
    bit          flushed;
    logic [31:0] line [4];
    idx  = int'(addr[7:2]);
    tg   = addr[24:8];
    off  = addr[1:0];
    base = {addr[24:2], 2'b00};
    for (int b = 0; b < 4; b++) line[b] = mem_word(base + 25'(b));

    s_read = 1'b1; s_addr = addr;
    if (fmode == 1) flush = 1'b1;
    @(negedge clk);
    check1("accept_wait", s_waitrequest, 1'b0);
    @(posedge clk); #1;
    s_read = 1'b0; s_addr = 25'($urandom); flush = 1'b0;
    if (fmode == 1) clear_model();
    exp_hit = mv[idx] && (mt[idx] == tg);
    if (fmode == 3) flush = 1'b1;
    @(negedge clk);
    check1("lookup_valid", s_readdata_valid, exp_hit);
    check1("lookup_wait", s_waitrequest, !exp_hit);
    flushed = (fmode == 3);
    if (exp_hit) begin
      exp_hits++;
      checkw("hit_data", s_readdata, line[off]);
      @(posedge clk); #1;
      flush = 1'b0;
      if (fmode == 3) clear_model();
      return;
    end
    exp_misses++;
    @(posedge clk); #1;
    flush = 1'b0;
    if (fmode == 3) clear_model();

    for (int k = 0; k <= int'(wcycles); k++) begin
      m_waitrequest = (k < int'(wcycles));
      @(negedge clk);
      check1("req_m_read", m_read, 1'b1);
      checkw("req_m_addr", 32'(m_addr), 32'(base));
      checkw("req_burst", 32'(m_burstcount), 32'd4);
      check1("req_wait", s_waitrequest, 1'b1);
      @(posedge clk); #1;
    end
    m_waitrequest = 1'b0;

    for (int b = 0; b < 4; b++) begin
      if ($urandom_range(0, 3) == 0) begin
        m_readdata_valid = 1'b0;
        @(negedge clk);
        check1("gap_wait", s_waitrequest, 1'b1);
        check1("gap_m_read", m_read, 1'b0);
        check1("gap_valid", s_readdata_valid, 1'b0);
        @(posedge clk); #1;
      end
      m_readdata_valid = 1'b1;
      m_readdata = line[b];
      if (fmode == 2 && b == 1) flush = 1'b1;
      @(negedge clk);
      check1("beat_wait", s_waitrequest, 1'b1);
      check1("beat_valid", s_readdata_valid, 1'b0);
      @(posedge clk); #1;
      m_readdata_valid = 1'b0;
      m_readdata = $urandom;
      if (fmode == 2 && b == 1) begin
        flush = 1'b0;
        flushed = 1'b1;
        clear_model();
      end
    end

    @(negedge clk);
    check1("resp_valid", s_readdata_valid, 1'b1);
    checkw("resp_data", s_readdata, line[off]);
    check1("resp_wait", s_waitrequest, 1'b0);
    check1("resp_m_read", m_read, 1'b0);
    @(posedge clk); #1;
    if (!flushed) begin
      mv[idx] = 1'b1;
      mt[idx] = tg;
    end
  endtask

  initial begin
    logic [24:0] a;
    int unsigned fm;
    rstn = 1'b0; s_addr = '0; s_byte_en = '0; s_writedata = '0;
    s_read = 1'b0; s_write = 1'b0; flush = 1'b0;
    m_readdata = '0; m_readdata_valid = 1'b0; m_waitrequest = 1'b0;
    clear_model();

    // Reset values
    @(posedge clk); #1;
    @(negedge clk);
    checkw("rst_readdata", s_readdata, 32'h0);
    check1("rst_valid", s_readdata_valid, 1'b0);
    check1("rst_wait", s_waitrequest, 1'b0);
    check1("rst_m_read", m_read, 1'b0);
    checkw("rst_m_addr", 32'(m_addr), 32'h0);
    @(posedge clk); #1;
    rstn = 1'b1;

    // Cold miss then back-to-back hits on the same line
    do_read(25'h10, 0, 0);
    for (int i = 0; i < 3; i++) begin
      s_read = 1'b1; s_addr = 25'h11 + 25'(i);
      @(negedge clk);
      check1("b2b_wait", s_waitrequest, 1'b0);
      check1("b2b_m_read", m_read, 1'b0);
      if (i > 0) begin
        check1("b2b_valid", s_readdata_valid, 1'b1);
        checkw("b2b_data", s_readdata, 32'hA0 + 32'(i));
        exp_hits++;
      end
      @(posedge clk); #1;
    end
    s_read = 1'b0;
    @(negedge clk);
    check1("b2b_valid", s_readdata_valid, 1'b1);
    checkw("b2b_data", s_readdata, 32'hA3);
    exp_hits++;
    @(posedge clk); #1;

    // Writes are accepted and produce nothing
    s_write = 1'b1; s_addr = 25'h10; s_writedata = 32'hDEADBEEF;
    @(negedge clk);
    check1("wr_wait", s_waitrequest, 1'b0);
    @(posedge clk); #1;
    s_write = 1'b0;
    @(negedge clk);
    check1("wr_valid", s_readdata_valid, 1'b0);
    @(posedge clk); #1;
    do_read(25'h10, 0, 0);

    // Single-cycle flush, then re-read misses
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    clear_model();
    do_read(25'h11, 0, 0);

    // Command stalled by memory for five cycles
    do_read(25'h80, 0, 5);

    // Flush mid-burst: data returned once, line not installed
    do_read(25'h40, 2, 0);
    do_read(25'h40, 0, 0);
    do_read(25'h41, 0, 0);
    // Flush on the accept edge forces a miss
    do_read(25'h42, 1, 0);
    // Flush during a hit compare still returns data
    do_read(25'h43, 3, 0);
    do_read(25'h43, 0, 0);

    // Stray memory beat outside a refill is ignored
    m_readdata_valid = 1'b1; m_readdata = 32'h12345678;
    @(negedge clk);
    check1("stray_valid", s_readdata_valid, 1'b0);
    check1("stray_wait", s_waitrequest, 1'b0);
    @(posedge clk); #1;
    m_readdata_valid = 1'b0;
    do_read(25'h41, 0, 0);

    // Reset in the middle of a refill
    s_read = 1'b1; s_addr = 25'h200;
    @(posedge clk); #1;
    s_read = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    m_readdata_valid = 1'b1; m_readdata = 32'h11111111;
    @(posedge clk); #1;
    m_readdata_valid = 1'b0;
    rstn = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b1;
    clear_model();
    exp_hits = 0; exp_misses = 0;
    @(negedge clk);
    check1("mrst_valid", s_readdata_valid, 1'b0);
    check1("mrst_wait", s_waitrequest, 1'b0);
    check1("mrst_m_read", m_read, 1'b0);
    checkw("mrst_m_addr", 32'(m_addr), 32'h0);
    checkw("mrst_readdata", s_readdata, 32'h0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      m_readdata_valid = 1'b1; m_readdata = 32'h22222222;
      @(negedge clk);
      check1("late_beat_valid", s_readdata_valid, 1'b0);
    end
    @(posedge clk); #1;
    m_readdata_valid = 1'b0;
    @(negedge clk);
    check1("late_beat_valid", s_readdata_valid, 1'b0);
    @(posedge clk); #1;
    do_read(25'h10, 0, 0);

    // Randomized reads over a small footprint to mix hits, misses and flushes
    for (int n = 0; n < 80; n++) begin
      a = '0;
      a[9:8] = 2'($urandom_range(0, 2));
      a[4:2] = 3'($urandom_range(0, 7));
      a[1:0] = 2'($urandom_range(0, 3));
      fm = $urandom_range(0, 9);
      if (fm > 2) fm = 0;
      if ($urandom_range(0, 14) == 0) begin
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        clear_model();
      end
      do_read(a, fm, $urandom_range(0, 2));
    end

`ifdef ICACHE_STATS_EN
    checkw("stat_hits", stat_hits, 32'(exp_hits));
    checkw("stat_misses", stat_misses, 32'(exp_misses));
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
